// File: rtl/lpc_pkg.sv
// Shared LPC constants and the autocorrelation reader FSM state type.
package lpc_pkg;

  localparam int unsigned NUM_LAGS  = 11;
  localparam int unsigned FRAME_LEN = 160;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDone
  } ar_state_e;

endpackage

// File: rtl/autocorr_reader.sv
// Reads R[0..NUM_LAGS-1] from the autocorrelation bank and streams them with valid/ready.
// Optional R[0]==0 early abort enabled by defining AUTOCORR_READER_ZERO_EN.
module autocorr_reader
  import lpc_pkg::*;
#(
  parameter int unsigned DATA_W   = lpc_pkg::DATA_W,
  parameter int unsigned NUM_LAGS = lpc_pkg::NUM_LAGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [NUM_LAGS-1:0] rsel,
  input  logic [DATA_W-1:0]   rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [3:0]          out_index,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                zero_energy
);

  localparam int unsigned KW = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
  localparam logic [KW-1:0] LastK = KW'(NUM_LAGS - 1);

  ar_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        index_q;
  logic              last_q;
  logic              zero_hit;

`ifdef AUTOCORR_READER_ZERO_EN
  logic zero_q;
  assign zero_hit    = (k_q == '0) && (rdata == '0);
  assign zero_energy = (state_q == StDone) && zero_q;
`else
  assign zero_hit    = 1'b0;
  assign zero_energy = 1'b0;
`endif

  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rsel      = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d = StFetch;
          k_d     = '0;
        end
      end
      StFetch: begin
        for (int unsigned i = 0; i < NUM_LAGS; i++) begin
          rsel[i] = (k_q == KW'(i));
        end
        state_d = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // last_q also covers the zero-energy abort after lag 0
          if (last_q) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == StFetch) begin
        data_q  <= rdata;
        index_q <= 4'(k_q);
        last_q  <= (k_q == LastK) || zero_hit;
      end
    end
  end

`ifdef AUTOCORR_READER_ZERO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q <= 1'b0;
    end else if (state_q == StFetch) begin
      zero_q <= zero_hit;
    end
  end
`endif

endmodule

// File: tb/tb_autocorr_reader.sv
// Randomized self-checking bench for autocorr_reader against a frame-level reference model.
module tb_autocorr_reader;

  localparam int NL = 11;
  localparam int DW = 32;
`ifdef AUTOCORR_READER_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NL-1:0] rsel;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          zero_energy;

  logic [DW-1:0] rbank [NL];

  int total = 0;
  int bad   = 0;

  autocorr_reader #(
    .DATA_W  (DW),
    .NUM_LAGS(NL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rsel       (rsel),
    .rdata      (rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .zero_energy(zero_energy)
  );

  always #5 clk = ~clk;

  // Register bank model: selected value appears combinationally.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NL; i++) begin
      if (rsel[i]) rdata = rbank[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsel"}, 64'(rsel), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_index"}, 64'(out_index), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_zero"}, 64'(zero_energy), 64'd0);
  endtask

  // kind 0: R[k]=100+k; 1: random nonzero R[0]; 2: R[0]=0, rest random
  task automatic fill(input int kind);
    for (int i = 0; i < NL; i++) begin
      rbank[i] = (kind == 0) ? DW'(100 + i) : $urandom;
    end
    if (kind == 1 && rbank[0] == 0) rbank[0] = 1;
    if (kind == 2) rbank[0] = '0;
  endtask

  // mode 0: ready always 1; 1: random ready; 2: 5-cycle stall on index 3
  task automatic run_frame(input string tag, input int mode, input int restart_idx,
                           input int abort_idx, input bit chk_cycles);
    int            exp_n;
    int            got;
    int            cyc;
    int            stall;
    bit            held;
    bit            finished;
    bit            zexp;
    logic [DW-1:0] hd;
    logic [3:0]    hi;
    logic [NL-1:0] sel_exp;

    zexp     = ZEN && (rbank[0] == '0);
    exp_n    = zexp ? 1 : NL;
    got      = 0;
    cyc      = 0;
    stall    = 0;
    held     = 1'b0;
    finished = 1'b0;
    start    = 1'b1;
    for (int it = 0; it < 400 && !finished; it++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      if (rsel != '0) begin
        sel_exp = NL'(1) << got;
        check({tag, "_rsel_fetch"}, 64'(rsel), 64'(sel_exp));
      end
      if (out_valid) check({tag, "_rsel_send"}, 64'(rsel), 64'd0);
      if (held) begin
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(out_data), 64'(hd));
        check({tag, "_hold_index"}, 64'(out_index), 64'(hi));
      end
      if (out_valid && abort_idx >= 0 && int'(out_index) == abort_idx) begin
        reset = 1'b0;
        #1;
        check_all_zero({tag, "_abort"});
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_index == 4'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && restart_idx >= 0 && int'(out_index) == restart_idx) start = 1'b1;
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (got < exp_n) begin
          check({tag, "_data"}, 64'(out_data), 64'(rbank[got]));
          check({tag, "_index"}, 64'(out_index), 64'(got));
          check({tag, "_last"}, 64'(out_last), 64'(got == exp_n - 1));
        end else begin
          check({tag, "_extra_word"}, 64'(got), 64'(exp_n - 1));
        end
        got++;
      end else if (out_valid) begin
        held = 1'b1;
        hd   = out_data;
        hi   = out_index;
      end
      if (done) begin
        check({tag, "_words"}, 64'(got), 64'(exp_n));
        check({tag, "_zero_at_done"}, 64'(zero_energy), 64'(zexp));
        if (chk_cycles) check({tag, "_cycles"}, 64'(cyc), 64'(2 * exp_n + 1));
        finished = 1'b1;
      end else begin
        check({tag, "_zero_idle"}, 64'(zero_energy), 64'd0);
      end
    end
    if (!finished) begin
      check({tag, "_timeout"}, 64'(got), 64'(exp_n + 1000));
      return;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_post_done"}, 64'(done), 64'd0);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // out_ready with no start must not begin anything
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
    end

    fill(0);
    run_frame("basic", 0, -1, -1, 1'b1);
    fill(0);
    run_frame("stall", 2, -1, -1, 1'b0);
    fill(1);
    run_frame("restart", 0, 5, -1, 1'b1);
    fill(1);
    run_frame("abort", 0, -1, 7, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("post_reset_busy", 64'(busy), 64'd0);
    end
    fill(1);
    run_frame("after_abort", 1, -1, -1, 1'b0);
    fill(2);
    run_frame("zero_r0", 0, -1, -1, 1'b1);
    for (int f = 0; f < 4; f++) begin
      fill(($urandom_range(0, 3) == 0) ? 2 : 1);
      run_frame("random", 1, -1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autocorr_reader.md
AUTOCORR_READER -- requirements
Module: autocorr_reader

Interface
REQ-001 Parameter DATA_W, default 32: width of one autocorrelation value R[k].
REQ-002 Parameter NUM_LAGS, default 11: number of R values (lags 0..NUM_LAGS-1) to read per frame.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle pulse: R bank is complete and readable.
REQ-006 rsel  output  NUM_LAGS  one-hot read select into the R register bank; bit k selects R[k]; all-zero when not reading.
REQ-007 rdata  input  DATA_W  R value selected by rsel, valid combinationally in the same cycle.
REQ-008 out_valid  output  1  out_data/out_index/out_last valid.
REQ-009 out_ready  input  1  downstream (Levinson-Durbin) accepts the current word.
REQ-010 out_data  output  DATA_W  captured R[k].
REQ-011 out_index  output  4  lag k of out_data.
REQ-012 out_last  output  1  high with the final word of the frame.
REQ-013 busy  output  1  high from the accepted start until the done pulse, inclusive.
REQ-014 done  output  1  one-cycle pulse after the last handshake.
REQ-015 zero_energy  output  1  one-cycle pulse, R[0]==0 abort (see Configuration).

Function
REQ-016 FSM states IDLE, FETCH, SEND, DONE; encoding comes from the shared package.
REQ-017 IDLE: rsel=0, out_valid=0; start=1 -> FETCH, lag pointer k=0.
REQ-018 FETCH (one cycle): rsel=one-hot(k); on the edge, out_data<=rdata, out_index<=k, out_last<=(k==NUM_LAGS-1) -> SEND.
REQ-019 SEND: out_valid=1 and out_data/out_index/out_last held stable until out_valid&&out_ready; rsel=0 while in SEND.
REQ-020 Handshake in SEND: if k==NUM_LAGS-1 -> DONE; else k<=k+1 -> FETCH.
REQ-021 out_valid is never withdrawn without a handshake; out_ready while out_valid=0 is ignored.
REQ-022 DONE (one cycle): done=1 -> IDLE.
REQ-023 Latency: start edge to first out_valid = 2 cycles; with out_ready held at 1, one word per 2 cycles and 2*NUM_LAGS+1 cycles from start to done.
REQ-024 start while busy is ignored and is neither queued nor restarted.
REQ-025 The lag pointer is sized for NUM_LAGS and never wraps; it resets to 0 on each accepted start.

Reset
REQ-026 Reset asserted, at any time including mid-frame -> state IDLE, k=0, rsel=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, zero_energy=0; the partial frame is discarded.
REQ-027 After reset deasserts, only a fresh start begins a frame.

Configuration
REQ-028 Macro AUTOCORR_READER_ZERO_EN defined: in FETCH with k==0 and rdata==0, out_last is captured as 1; after that handshake the FSM goes to DONE, and zero_energy pulses together with done; lags 1..NUM_LAGS-1 are not read.
REQ-029 Macro AUTOCORR_READER_ZERO_EN undefined: zero_energy is tied to 0 and all NUM_LAGS words are always sent.

Structure
REQ-030 Package lpc_pkg holds the constants NUM_LAGS=11, FRAME_LEN=160, DATA_W=32 and the FSM state type of this block.
REQ-031 No sub-module; the one-hot rsel is decoded from k inline.

Verification
REQ-032 start, out_ready=1, R[k]=100+k -> out_data 100..110 on out_index 0..10, out_last only on index 10, done at cycle 23 after start.
REQ-033 out_ready=0 for 5 cycles on index 3 -> out_valid/out_data=103 held stable; rsel=0 throughout; resumes at index 4.
REQ-034 start pulsed again at index 5 -> ignored; exactly 11 words, one done.
REQ-035 reset asserted during SEND at index 7 -> all outputs 0 asynchronously; a later start yields a full frame from index 0.
REQ-036 AUTOCORR_READER_ZERO_EN set, R[0]=0 -> single word (index 0, out_last=1); zero_energy and done pulse together; rsel never selects bit 1.
REQ-037 AUTOCORR_READER_ZERO_EN unset, R[0]=0 -> all 11 words sent; zero_energy stays 0.
